// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Single-port RAM arbiter between the instruction and data
//               request paths of a request unit. Data writes beat data reads,
//               which beat instruction fetches. Each access is latched on
//               leaving IDLE, held until the RAM reports ACCESS or ERROR,
//               and completed with a one-cycle ihit/dhit pulse in RESP.
//               Optional build macro ARB_TIMEOUT_EN adds a per-access wait
//               limit of TIMEOUT_CYCLES cycles, after which the access is
//               abandoned and mem_err is raised.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    // request unit side
    input  logic        imemREN,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] imemaddr,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    // RAM side
    input  logic [1:0]  ramstate,
    input  logic [31:0] ramload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    // status
    output logic        mem_err
);

    // RAM status encoding (FREE, BUSY, ACCESS, ERROR in declaration order)
    localparam logic [1:0] c_RAM_FREE   = 2'd0;
    localparam logic [1:0] c_RAM_BUSY   = 2'd1;
    localparam logic [1:0] c_RAM_ACCESS = 2'd2;
    localparam logic [1:0] c_RAM_ERROR  = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        IREQ = 3'd1,
        DREQ = 3'd2,
        DWR  = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    // latched access
    logic [31:0] r_addr;
    logic [31:0] r_store;
    logic        r_is_instr;     // access in flight (and its RESP) belongs to the fetch path

    // read data and status registers
    logic [31:0] r_iload;
    logic [31:0] r_dload;
    logic        r_mem_err;

    // FSM decode
    logic        w_ren;
    logic        w_wen;
    logic        w_ihit;
    logic        w_dhit;
    logic        w_leave_idle;
    logic        w_cap_i;
    logic        w_cap_d;
    logic        w_set_err;
    logic        w_in_req;
    logic        w_ram_done;     // RAM gave a final answer (ACCESS or ERROR) this cycle
    logic        w_timeout;

    // A zero limit would abandon every access before the RAM could answer.
    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_param
        end
    endgenerate

    assign w_in_req   = (r_state == IREQ) || (r_state == DREQ) || (r_state == DWR);
    assign w_ram_done = (ramstate == c_RAM_ACCESS) || (ramstate == c_RAM_ERROR);

`ifdef ARB_TIMEOUT_EN
    localparam int               WAIT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] c_WAIT_LIM = WAIT_W'(TIMEOUT_CYCLES);

    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_inc;

    assign w_wait_inc = r_wait + 1'b1;
    // The cycle that would bring the count to the limit is the last one waited.
    assign w_timeout  = w_in_req && !w_ram_done && (w_wait_inc == c_WAIT_LIM);

    // Wait counter: zero whenever idle so every request state starts fresh.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wait <= '0;
        end else if (!w_in_req) begin
            r_wait <= '0;
        end else if (!w_ram_done) begin
            r_wait <= w_wait_inc;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        w_next_state = r_state;
        w_ren        = 1'b0;
        w_wen        = 1'b0;
        w_ihit       = 1'b0;
        w_dhit       = 1'b0;
        w_leave_idle = 1'b0;
        w_cap_i      = 1'b0;
        w_cap_d      = 1'b0;
        w_set_err    = 1'b0;

        case (r_state)
            IDLE: begin
                w_leave_idle = dmemWEN || dmemREN || imemREN;
                if (dmemWEN) begin
                    w_next_state = DWR;
                end else if (dmemREN) begin
                    w_next_state = DREQ;
                end else if (imemREN) begin
                    w_next_state = IREQ;
                end
            end

            IREQ, DREQ, DWR: begin
                w_ren = (r_state != DWR);
                w_wen = (r_state == DWR);
                if (ramstate == c_RAM_ACCESS) begin
                    w_next_state = RESP;
                    w_cap_i      = (r_state == IREQ);
                    w_cap_d      = (r_state == DREQ);
                end else if (ramstate == c_RAM_ERROR) begin
                    w_next_state = IDLE;
                    w_set_err    = 1'b1;
                end else if (w_timeout) begin
                    w_next_state = IDLE;
                    w_set_err    = 1'b1;
                end
                // FREE / BUSY: hold the access as it is
            end

            RESP: begin
                w_ihit       = r_is_instr;
                w_dhit       = !r_is_instr;
                w_next_state = IDLE;
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Access latch: address, write data and path are frozen when leaving IDLE.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_addr     <= '0;
            r_store    <= '0;
            r_is_instr <= 1'b0;
        end else if (w_leave_idle) begin
            r_addr     <= (w_next_state == IREQ) ? imemaddr : daddr;
            r_is_instr <= (w_next_state == IREQ);
            if (w_next_state == DWR) begin
                r_store <= dstore;
            end
        end
    end

    // Read data capture on the ACCESS edge; values hold until the next capture.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_iload <= '0;
            r_dload <= '0;
        end else begin
            if (w_cap_i) begin
                r_iload <= ramload;
            end
            if (w_cap_d) begin
                r_dload <= ramload;
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_mem_err <= 1'b0;
        end else if (w_set_err) begin
            r_mem_err <= 1'b1;
        end
    end

    assign ihit     = w_ihit;
    assign dhit     = w_dhit;
    assign iload    = r_iload;
    assign dload    = r_dload;
    assign ramREN   = w_ren;
    assign ramWEN   = w_wen;
    assign ramaddr  = r_addr;
    assign ramstore = r_store;
    assign mem_err  = r_mem_err;

    // FREE and BUSY are handled by the hold path; named here for readability.
    logic w_ram_waiting;
    assign w_ram_waiting = (ramstate == c_RAM_FREE) || (ramstate == c_RAM_BUSY);
    logic w_unused;
    assign w_unused = w_ram_waiting;

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, RAM wait-cycle limit per access; used only with ARB_TIMEOUT_EN.
REQ-002 Clock is CLK and reset is nRST: one clock, reset asynchronous and active-low.
REQ-003 CLK  in  1  system clock; all state updates on rising edge.
REQ-004 nRST  in  1  asynchronous active-low reset.
REQ-005 imemREN  in  1  instruction read request from request unit.
REQ-006 dmemREN  in  1  data read request from request unit.
REQ-007 dmemWEN  in  1  data write request from request unit.
REQ-008 imemaddr  in  32  instruction word address.
REQ-009 daddr  in  32  data word address.
REQ-010 dstore  in  32  data write value.
REQ-011 ramstate  in  2  RAM status, cpu_types_pkg ramstate_t (FREE, BUSY, ACCESS, ERROR).
REQ-012 ramload  in  32  RAM read data.
REQ-013 ihit  out  1  one-cycle instruction completion pulse.
REQ-014 dhit  out  1  one-cycle data completion pulse.
REQ-015 iload  out  32  registered instruction word.
REQ-016 dload  out  32  registered data read word.
REQ-017 ramREN, ramWEN  out  1 each  RAM read/write strobes.
REQ-018 ramaddr  out  32  RAM address.
REQ-019 ramstore  out  32  RAM write data.
REQ-020 mem_err  out  1  sticky error flag.

Function
REQ-021 FSM states: IDLE, IREQ, DREQ, DWR, RESP.
REQ-022 IDLE priority: dmemWEN -> DWR; else dmemREN -> DREQ; else imemREN -> IREQ; else stay.
REQ-023 On leaving IDLE, latch address (and dstore for DWR) into registers; RAM outputs are driven only from latched values.
REQ-024 IREQ/DREQ: ramREN=1, ramWEN=0. DWR: ramWEN=1, ramREN=0. Both strobes are 0 in IDLE and RESP.
REQ-025 In a request state, ramstate FREE or BUSY -> hold state and outputs.
REQ-026 ACCESS -> go to RESP. For IREQ/DREQ, capture ramload into iload/dload respectively, in the same edge.
REQ-027 ERROR -> go to IDLE, set mem_err, no hit.
REQ-028 RESP lasts exactly one cycle and asserts ihit (from IREQ) or dhit (from DREQ/DWR), then returns to IDLE.
REQ-029 Minimum latency: request seen in IDLE at cycle 0, ACCESS at cycle 1, hit at cycle 2.
REQ-030 Requests are ignored in RESP.
REQ-031 iload/dload hold their value until the next capture.
REQ-032 ihit and dhit are never high together.
REQ-033 Request inputs changing during a request state do not affect the access in flight.

Reset
REQ-034 nRST low, asynchronously and including mid-access: state=IDLE, all outputs 0, latches 0, mem_err=0, any access in flight abandoned without hit.

Configuration
REQ-035 With ARB_TIMEOUT_EN defined:
- a wait counter clears on entry to each request state and increments each cycle without ACCESS/ERROR;
- when it reaches TIMEOUT_CYCLES, go to IDLE, set mem_err, no hit.
REQ-036 Without ARB_TIMEOUT_EN: no counter is synthesized, request states wait indefinitely, and mem_err is set only by ERROR.

Verification
REQ-037 imemREN=1, imemaddr=0x40, ramstate ACCESS at cycle 1, ramload=0x8C010004 -> ramREN=1 with ramaddr=0x40 at cycle 1; ihit=1 with iload=0x8C010004 at cycle 2 only.
REQ-038 imemREN=dmemREN=1 together, daddr=0x100 -> DREQ first with ramaddr=0x100, dhit pulse, then IREQ.
REQ-039 dmemWEN=1, daddr=0x200, dstore=0xDEADBEEF, BUSY for 3 cycles then ACCESS -> ramWEN=1 for 4 cycles, ramstore=0xDEADBEEF, single dhit, dload unchanged.
REQ-040 IREQ with ramstate=ERROR -> IDLE next cycle, mem_err=1 until reset, ihit stays 0.
REQ-041 nRST pulsed low while in DREQ -> outputs 0 immediately; after release IDLE, no dhit.
REQ-042 With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, ramstate held BUSY -> return to IDLE after 16 wait cycles with mem_err=1. Without the macro, ramREN stays 1 beyond 100 cycles.
